// File: rtl/mcpu_pkg.sv
// Shared MCPU constants and program-loader state encodings.
package mcpu_pkg;

    localparam int WORD_SIZE      = 16;
    localparam int ADDR_SIZE      = 8;
    localparam int RAM_SIZE       = 2 ** ADDR_SIZE;
    localparam int BYTE_SIZE      = 8;
    localparam int BYTES_PER_WORD = WORD_SIZE / BYTE_SIZE;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_LEN   = 3'd1,
        LD_DATA  = 3'd2,
        LD_WRITE = 3'd3,
        LD_CSUM  = 3'd4,
        LD_DONE  = 3'd5,
        LD_ERROR = 3'd6
    } ld_state_t;

endpackage

// File: rtl/mcpu_word_packer.sv
// Packs stream bytes MS-first into one instruction word; word_ready flags the
// byte that completes a word.
module mcpu_word_packer #(
    parameter int WORD_SIZE = mcpu_pkg::WORD_SIZE,
    parameter int BYTE_SIZE = mcpu_pkg::BYTE_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic [BYTE_SIZE-1:0] byte_in,
    output logic [WORD_SIZE-1:0] word,
    output logic                 word_ready
);

    localparam int BPW = WORD_SIZE / BYTE_SIZE;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0]        cnt;
    logic [WORD_SIZE-1:0] shreg;

    assign word       = shreg;
    assign word_ready = shift_en && (cnt == CW'(BPW - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (clear) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (shift_en) begin
            shreg <= (shreg << BYTE_SIZE) | WORD_SIZE'(byte_in);
            cnt   <= word_ready ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mcpu_prog_loader.sv
// Boot loader: LEN / N words / CSUM byte stream into MCPU instruction RAM,
// releasing cpu_reset only after an XOR-checksum-clean load.
module mcpu_prog_loader #(
    parameter int WORD_SIZE = mcpu_pkg::WORD_SIZE,
    parameter int ADDR_SIZE = mcpu_pkg::ADDR_SIZE,
    parameter int BYTE_SIZE = mcpu_pkg::BYTE_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BYTE_SIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [WORD_SIZE-1:0] ram_wdata,
    output logic                 cpu_reset,
    output logic                 done,
    output logic                 error
);

    import mcpu_pkg::*;

    // Word count is one bit wider so a full-RAM frame (N=0) reads as 2**ADDR_SIZE.
    localparam int WCW = ADDR_SIZE + 1;

    ld_state_t            state, state_n;
    logic [ADDR_SIZE-1:0] addr;
    logic [WCW-1:0]       wcnt, nwords, wcnt_inc;
    logic [BYTE_SIZE-1:0] csum;
    logic                 xfer, start_ok, shift_en, word_ready;
    logic [WORD_SIZE-1:0] word;

    assign in_ready  = (state == LD_LEN) || (state == LD_DATA) || (state == LD_CSUM);
    assign xfer      = in_valid && in_ready;
    assign start_ok  = start && ((state == LD_IDLE) || (state == LD_DONE) || (state == LD_ERROR));
    assign shift_en  = xfer && (state == LD_DATA);
    assign wcnt_inc  = wcnt + 1'b1;
    assign ram_we    = (state == LD_WRITE);
    assign ram_addr  = addr;
    assign ram_wdata = word;

    mcpu_word_packer #(
        .WORD_SIZE (WORD_SIZE),
        .BYTE_SIZE (BYTE_SIZE)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .shift_en   (shift_en),
        .byte_in    (in_data),
        .word       (word),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LD_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            LD_IDLE, LD_DONE, LD_ERROR: if (start) state_n = LD_LEN;
            LD_LEN:   if (xfer) state_n = LD_DATA;
            LD_DATA:  if (word_ready) state_n = LD_WRITE;
            LD_WRITE: state_n = (wcnt_inc == nwords) ? LD_CSUM : LD_DATA;
            LD_CSUM:  if (xfer) state_n = (in_data == csum) ? LD_DONE : LD_ERROR;
            default:  state_n = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr      <= '0;
            wcnt      <= '0;
            nwords    <= '0;
            csum      <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else if (start_ok) begin
            addr      <= '0;
            wcnt      <= '0;
            csum      <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state)
                LD_LEN: if (xfer) begin
                    nwords <= (in_data == '0) ? {1'b1, {ADDR_SIZE{1'b0}}} : WCW'(in_data);
                    csum   <= csum ^ in_data;
                end
                LD_DATA: if (xfer) csum <= csum ^ in_data;
                LD_WRITE: begin
                    // addr wraps to 0 after a full-RAM load; no write follows
                    addr <= addr + 1'b1;
                    wcnt <= wcnt_inc;
                end
                LD_CSUM: if (xfer) begin
                    if (in_data == csum) begin
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                    end else begin
                        error     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mcpu_prog_loader.sv
// Directed bench for the program loader: frame model predicts every RAM write,
// a monitor checks writes and in_ready each cycle, literals pin the results.
module tb_mcpu_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int vectors    = 0;
    int miscompares = 0;
    int wr_count   = 0;
    logic loading  = 1'b0;

    logic [7:0]  exp_addr[$];
    logic [15:0] exp_data[$];
    logic [15:0] wq[$];
    logic [15:0] obs_mem[256];

    always #5 clk = ~clk;

    mcpu_prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write must be the next one the frame model predicted.
    always @(negedge clk) begin
        if (reset === 1'b1 && ram_we === 1'b1) begin
            wr_count++;
            if (exp_addr.size() == 0) begin
                check("unexpected_write_addr", {24'h0, ram_addr}, 32'hFFFF_FFFF);
            end else begin
                check("write_addr", {24'h0, ram_addr}, {24'h0, exp_addr.pop_front()});
                check("write_data", {16'h0, ram_wdata}, {16'h0, exp_data.pop_front()});
            end
            obs_mem[ram_addr] = ram_wdata;
        end
        if (reset === 1'b1 && loading)
            check("in_ready_vs_write", {31'h0, in_ready}, {31'h0, ~ram_we});
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int   gap;
        int   n;
        logic rdy;
        gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk) rdy = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 100);
        if (!rdy) check("byte_accept_timeout", 32'h0, 32'h1);
        in_valid = 1'b0;
    endtask

    // Sends LEN, the words in wq, then CSUM (optionally corrupted); queues the expected writes.
    task automatic send_frame(input logic [7:0] len, input bit good, input int maxgap, input int start_idx);
        logic [7:0] cs;
        int         k;
        cs = len;
        foreach (wq[i]) begin
            cs ^= wq[i][15:8] ^ wq[i][7:0];
            exp_addr.push_back(i[7:0]);
            exp_data.push_back(wq[i]);
        end
        if (!good) cs ^= 8'h01;
        loading = 1'b1;
        send_byte(len, maxgap);
        k = 0;
        foreach (wq[i]) begin
            for (int j = 0; j < 2; j++) begin
                if (k == start_idx) pulse_start();
                send_byte(j == 0 ? wq[i][15:8] : wq[i][7:0], maxgap);
                k++;
            end
        end
        send_byte(cs, maxgap);
        loading = 1'b0;
    endtask

    task automatic basic_words();
        wq.delete();
        wq.push_back(16'h1234);
        wq.push_back(16'hABCD);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic cr);
        check({tag, "_done"},      {31'h0, done},      {31'h0, d});
        check({tag, "_error"},     {31'h0, error},     {31'h0, e});
        check({tag, "_cpu_reset"}, {31'h0, cpu_reset}, {31'h0, cr});
        check({tag, "_in_ready"},  {31'h0, in_ready},  32'h0);
        check({tag, "_pending"},   exp_addr.size(),    32'h0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  {31'h0, in_ready},  32'h0);
        check({tag, "_ram_we"},    {31'h0, ram_we},    32'h0);
        check({tag, "_ram_addr"},  {24'h0, ram_addr},  32'h0);
        check({tag, "_ram_wdata"}, {16'h0, ram_wdata}, 32'h0);
        check({tag, "_cpu_reset"}, {31'h0, cpu_reset}, 32'h1);
        check({tag, "_done"},      {31'h0, done},      32'h0);
        check({tag, "_error"},     {31'h0, error},     32'h0);
    endtask

    initial begin
        int base;
        foreach (obs_mem[i]) obs_mem[i] = 16'hDEAD;
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #12;
        check_reset_values("por");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Basic frame 02 12 34 AB CD 42
        basic_words();
        pulse_start();
        send_frame(8'h02, 1'b1, 0, -1);
        check_status("basic", 1'b1, 1'b0, 1'b0);
        check("basic_mem0", {16'h0, obs_mem[0]}, 32'h1234);
        check("basic_mem1", {16'h0, obs_mem[1]}, 32'hABCD);
        check("basic_mem2_untouched", {16'h0, obs_mem[2]}, 32'hDEAD);

        // Bad checksum 02 12 34 AB CD 43
        obs_mem[0] = 16'h0; obs_mem[1] = 16'h0;
        pulse_start();
        check("restart_cpu_reset", {31'h0, cpu_reset}, 32'h1);
        check("restart_done", {31'h0, done}, 32'h0);
        send_frame(8'h02, 1'b0, 0, -1);
        check_status("badcsum", 1'b0, 1'b1, 1'b1);
        check("badcsum_mem1", {16'h0, obs_mem[1]}, 32'hABCD);

        // Basic frame with random valid gaps
        pulse_start();
        check("err_restart_error", {31'h0, error}, 32'h0);
        send_frame(8'h02, 1'b1, 3, -1);
        check_status("stall", 1'b1, 1'b0, 1'b0);

        // Start during DATA is ignored
        pulse_start();
        send_frame(8'h02, 1'b1, 0, 1);
        check_status("start_in_data", 1'b1, 1'b0, 1'b0);

        // Full RAM: N=0, w[i]=i*0x0101, checksum is 0x00
        wq.delete();
        for (int i = 0; i < 256; i++) wq.push_back({i[7:0], i[7:0]});
        base = wr_count;
        pulse_start();
        send_frame(8'h00, 1'b1, 0, -1);
        repeat (5) @(posedge clk);
        #1;
        check_status("full", 1'b1, 1'b0, 1'b0);
        check("full_write_count", wr_count - base, 32'd256);
        check("full_mem80", {16'h0, obs_mem[8'h80]}, 32'h8080);
        check("full_memFF", {16'h0, obs_mem[8'hFF]}, 32'hFFFF);
        check("full_addr_wrapped", {24'h0, ram_addr}, 32'h0);

        // Async reset after 3 data bytes, then a clean basic load
        pulse_start();
        loading = 1'b1;
        exp_addr.push_back(8'h00); exp_data.push_back(16'h1234);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'hAB, 0);
        loading = 1'b0;
        reset = 1'b0;
        #2;
        check_reset_values("midload");
        check("midload_pending", exp_addr.size(), 32'h0);
        #1 reset = 1'b1;
        in_valid = 1'b1; in_data = 8'hCD;
        @(posedge clk); #1;
        check("idle_in_ready", {31'h0, in_ready}, 32'h0);
        check("idle_cpu_reset", {31'h0, cpu_reset}, 32'h1);
        in_valid = 1'b0;
        basic_words();
        obs_mem[1] = 16'h0;
        pulse_start();
        send_frame(8'h02, 1'b1, 0, -1);
        check_status("after_reset", 1'b1, 1'b0, 1'b0);
        check("after_reset_mem1", {16'h0, obs_mem[1]}, 32'hABCD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
